// File: rtl/mem_responder.sv
// Latency-programmable word memory target serving a fetch port and a data port.
// Round-robin arbitration; one transaction in flight; registered one-cycle acks.
module mem_responder #(
  parameter int    WORD     = 16,
  parameter int    DEPTH    = 256,
  parameter int    ADDR_W   = 16,
  parameter int    LATENCY  = 1,
  parameter string MEM_INIT = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [WORD-1:0]   f_instr,
  output logic [WORD-1:0]   f_imm,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD-1:0]   d_wdata,
  output logic              d_ack,
  output logic [WORD-1:0]   d_rdata,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = ADDR_W - 1;
  localparam int MA_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic pref_f;
  logic pick_f;
  logic accept;
  logic go_resp;

  logic             l_fetch;
  logic             l_we;
  logic [IDX_W-1:0] l_idx;
  logic [WORD-1:0]  l_wdata;

  logic             a_fetch;
  logic             a_we;
  logic [IDX_W-1:0] a_idx;
  logic [IDX_W-1:0] a_nxt;
  logic [WORD-1:0]  a_wdata;
  logic             a_ok;
  logic             n_ok;

  logic [WORD-1:0] mem [DEPTH];
  logic unused_addr_lsb;

  assign unused_addr_lsb = f_addr[0] ^ d_addr[0];
  assign busy   = (state != IDLE);
  assign pick_f = f_req & (~d_req | pref_f);

  // In IDLE the access uses live inputs so LATENCY==1 can answer at once.
  always_comb begin
    a_fetch = l_fetch;
    a_we    = l_we;
    a_idx   = l_idx;
    a_wdata = l_wdata;
    if (state == IDLE) begin
      a_fetch = pick_f;
      a_we    = d_we & ~pick_f;
      a_idx   = pick_f ? f_addr[ADDR_W-1:1]
                       : d_addr[ADDR_W-1:1];
      a_wdata = d_wdata;
    end
  end

  assign a_nxt = a_idx + IDX_W'(1);
  assign a_ok  = a_idx < IDX_W'(DEPTH);
  assign n_ok  = a_ok && (a_nxt < IDX_W'(DEPTH));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    go_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (f_req || d_req) begin
          accept = 1'b1;
          cnt_n  = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_n = RESP;
            go_resp = 1'b1;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt_n == 4'd0) begin
          state_n = RESP;
          go_resp = 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      pref_f <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) pref_f <= ~pick_f;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      l_fetch <= 1'b0;
      l_we    <= 1'b0;
      l_idx   <= '0;
      l_wdata <= '0;
    end else if (accept) begin
      l_fetch <= a_fetch;
      l_we    <= a_we;
      l_idx   <= a_idx;
      l_wdata <= a_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_ack   <= 1'b0;
      d_ack   <= 1'b0;
      err     <= 1'b0;
      f_instr <= '0;
      f_imm   <= '0;
      d_rdata <= '0;
    end else begin
      f_ack <= go_resp & a_fetch;
      d_ack <= go_resp & ~a_fetch;
      err   <= go_resp & ~a_ok;
      if (go_resp && a_fetch) begin
        f_instr <= a_ok ? mem[a_idx[MA_W-1:0]] : '0;
        f_imm   <= n_ok ? mem[a_nxt[MA_W-1:0]] : '0;
      end
      if (go_resp && !a_fetch) begin
        d_rdata <= (a_ok && !a_we) ? mem[a_idx[MA_W-1:0]] : '0;
      end
    end
  end

  // A write commits only on the edge entering RESP, so reset aborts it.
  always_ff @(posedge clk) begin
    if (!reset && go_resp && !a_fetch && a_we && a_ok) begin
      mem[a_idx[MA_W-1:0]] <= a_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at LATENCY 1, 3 and 4.
// Instance 0: L=1, instance 1: L=3, instance 2: L=4.
module tb_mem_responder;

  logic clk;
  logic reset;

  logic        f_req   [3];
  logic [15:0] f_addr  [3];
  logic        f_ack   [3];
  logic [15:0] f_instr [3];
  logic [15:0] f_imm   [3];
  logic        d_req   [3];
  logic        d_we    [3];
  logic [15:0] d_addr  [3];
  logic [15:0] d_wdata [3];
  logic        d_ack   [3];
  logic [15:0] d_rdata [3];
  logic        err     [3];
  logic        busy    [3];

  int n_run;
  int n_fail;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .WORD(16),
      .DEPTH(256),
      .ADDR_W(16),
      .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .MEM_INIT("")
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .f_req(f_req[g]),
      .f_addr(f_addr[g]),
      .f_ack(f_ack[g]),
      .f_instr(f_instr[g]),
      .f_imm(f_imm[g]),
      .d_req(d_req[g]),
      .d_we(d_we[g]),
      .d_addr(d_addr[g]),
      .d_wdata(d_wdata[g]),
      .d_ack(d_ack[g]),
      .d_rdata(d_rdata[g]),
      .err(err[g]),
      .busy(busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic data_op(input int k,
                         input logic we,
                         input logic [15:0] addr,
                         input logic [15:0] wdata,
                         output logic [15:0] rd,
                         output logic er,
                         output int cyc);
    d_we[k]    = we;
    d_addr[k]  = addr;
    d_wdata[k] = wdata;
    d_req[k]   = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (d_ack[k] !== 1'b1 && cyc < 40);
    chk($sformatf("d_ack_seen%0d", k), 32'(d_ack[k]), 1);
    rd = d_rdata[k];
    er = err[k];
    d_req[k] = 1'b0;
    tick();
  endtask

  task automatic fetch_op(input int k,
                          input logic [15:0] addr,
                          output logic [15:0] ins,
                          output logic [15:0] imm,
                          output logic er,
                          output int cyc);
    f_addr[k] = addr;
    f_req[k]  = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (f_ack[k] !== 1'b1 && cyc < 40);
    chk($sformatf("f_ack_seen%0d", k), 32'(f_ack[k]), 1);
    ins = f_instr[k];
    imm = f_imm[k];
    er  = err[k];
    f_req[k] = 1'b0;
    tick();
  endtask

  initial begin
    logic [15:0] rd, ins, imm;
    logic er, seen;
    int cyc;
    logic [11:0] pd0, pf0, pd1, pf1;

    n_run  = 0;
    n_fail = 0;
    reset  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      f_req[k]   = 1'b0;
      f_addr[k]  = '0;
      d_req[k]   = 1'b0;
      d_we[k]    = 1'b0;
      d_addr[k]  = '0;
      d_wdata[k] = '0;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_f_ack%0d", k), 32'(f_ack[k]), 0);
      chk($sformatf("rst_d_ack%0d", k), 32'(d_ack[k]), 0);
      chk($sformatf("rst_err%0d", k), 32'(err[k]), 0);
      chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 0);
      chk($sformatf("rst_instr%0d", k), 32'(f_instr[k]), 0);
      chk($sformatf("rst_imm%0d", k), 32'(f_imm[k]), 0);
      chk($sformatf("rst_rdata%0d", k), 32'(d_rdata[k]), 0);
    end
    reset = 1'b0;

    // Both ports held high straight out of reset: data, fetch, data.
    for (int k = 0; k < 2; k++) begin
      f_req[k] = 1'b1;
      d_req[k] = 1'b1;
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      pd0[i] = d_ack[0];
      pf0[i] = f_ack[0];
      pd1[i] = d_ack[1];
      pf1[i] = f_ack[1];
    end
    for (int k = 0; k < 2; k++) begin
      f_req[k] = 1'b0;
      d_req[k] = 1'b0;
    end
    tick();
    chk("rr_d_l1", 32'(pd0), 32'h111);
    chk("rr_f_l1", 32'(pf0), 32'h444);
    chk("rr_d_l3", 32'(pd1), 32'h404);
    chk("rr_f_l3", 32'(pf1), 32'h040);

    // Fetch with trailing immediate, L=1.
    data_op(0, 1'b1, 16'h0000, 16'h0801, rd, er, cyc);
    data_op(0, 1'b1, 16'h0002, 16'h0005, rd, er, cyc);
    fetch_op(0, 16'h0000, ins, imm, er, cyc);
    chk("fetch_lat", 32'(cyc), 1);
    chk("fetch_instr", 32'(ins), 32'h0801);
    chk("fetch_imm", 32'(imm), 32'h0005);
    chk("fetch_err", 32'(er), 0);
    chk("fetch_pulse", 32'(f_ack[0]), 0);

    // Write then aliased odd-address read, L=3.
    data_op(1, 1'b1, 16'h0010, 16'hBEEF, rd, er, cyc);
    chk("wr_lat", 32'(cyc), 3);
    chk("wr_rdata", 32'(rd), 0);
    chk("wr_err", 32'(er), 0);
    data_op(1, 1'b0, 16'h0011, 16'h0000, rd, er, cyc);
    chk("rd_lat", 32'(cyc), 3);
    chk("rd_alias", 32'(rd), 32'hBEEF);

    // Top of memory and out-of-range accesses.
    data_op(1, 1'b1, 16'h01FE, 16'hA5A5, rd, er, cyc);
    data_op(1, 1'b1, 16'h0000, 16'h0F0F, rd, er, cyc);
    fetch_op(1, 16'h01FE, ins, imm, er, cyc);
    chk("top_instr", 32'(ins), 32'hA5A5);
    chk("top_imm", 32'(imm), 0);
    chk("top_err", 32'(er), 0);
    data_op(1, 1'b1, 16'h0200, 16'hDEAD, rd, er, cyc);
    chk("oor_wr_err", 32'(er), 1);
    chk("oor_wr_lat", 32'(cyc), 3);
    data_op(1, 1'b0, 16'h0000, 16'h0000, rd, er, cyc);
    chk("oor_wr_dropped", 32'(rd), 32'h0F0F);
    data_op(1, 1'b0, 16'h0200, 16'h0000, rd, er, cyc);
    chk("oor_rd_data", 32'(rd), 0);
    chk("oor_rd_err", 32'(er), 1);

    // Reset two cycles into an L=4 write aborts it.
    data_op(2, 1'b1, 16'h0004, 16'h5555, rd, er, cyc);
    data_op(2, 1'b0, 16'h0004, 16'h0000, rd, er, cyc);
    chk("l4_lat", 32'(cyc), 4);
    chk("l4_old", 32'(rd), 32'h5555);
    d_we[2]    = 1'b1;
    d_addr[2]  = 16'h0004;
    d_wdata[2] = 16'h1234;
    d_req[2]   = 1'b1;
    tick();
    tick();
    reset    = 1'b1;
    d_req[2] = 1'b0;
    tick();
    chk("mid_rst_ack", 32'(d_ack[2]), 0);
    chk("mid_rst_busy", 32'(busy[2]), 0);
    chk("mid_rst_err", 32'(err[2]), 0);
    chk("mid_rst_rdata", 32'(d_rdata[2]), 0);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (8) begin
      tick();
      seen = seen | d_ack[2];
    end
    chk("mid_rst_no_ack", 32'(seen), 0);
    data_op(2, 1'b0, 16'h0004, 16'h0000, rd, er, cyc);
    chk("mid_rst_kept", 32'(rd), 32'h5555);

    // Address/data changes after acceptance are ignored.
    data_op(2, 1'b1, 16'h0022, 16'h7777, rd, er, cyc);
    d_we[2]    = 1'b1;
    d_addr[2]  = 16'h0020;
    d_wdata[2] = 16'hCAFE;
    d_req[2]   = 1'b1;
    tick();
    d_addr[2]  = 16'h0022;
    d_wdata[2] = 16'h0BAD;
    chk("late_busy", 32'(busy[2]), 1);
    cyc = 1;
    while (d_ack[2] !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("late_lat", 32'(cyc), 4);
    d_req[2] = 1'b0;
    tick();
    data_op(2, 1'b0, 16'h0020, 16'h0000, rd, er, cyc);
    chk("late_addr_data", 32'(rd), 32'hCAFE);
    data_op(2, 1'b0, 16'h0022, 16'h0000, rd, er, cyc);
    chk("late_other", 32'(rd), 32'h7777);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
